// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the writeback arbiter: requester indices, request and write-port structs.
package writeback_arbiter_pkg;

    localparam int WB_DATA_WIDTH    = 19;
    localparam int WB_WIDTH         = 8;
    localparam int WB_VECTOR_SIZE   = 8;
    localparam int WB_ADDRESS_WIDTH = 4;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    typedef struct packed {
        logic                                 isVector;
        logic [WB_ADDRESS_WIDTH-1:0]          address;
        logic [WB_DATA_WIDTH-1:0]             scalarData;
        logic [WB_VECTOR_SIZE*WB_WIDTH-1:0]   vectorData;
    } wb_req_t;

    typedef struct packed {
        logic                                 enScalar;
        logic                                 enVector;
        logic [WB_ADDRESS_WIDTH-1:0]          address;
        logic [WB_DATA_WIDTH-1:0]             scalarData;
        logic [WB_VECTOR_SIZE*WB_WIDTH-1:0]   vectorData;
    } wb_port_t;

endpackage

// File: rtl/writeback_arbiter_rr.sv
// rr_arbiter2: two-input round-robin arbiter; the pointer names the favoured requester on contention.
module rr_arbiter2
    import writeback_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic rrPtr;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rrPtr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After a grant the other requester becomes favoured.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rrPtr <= 1'b0;
        else if (|grant)
            rrPtr <= grant[REQ_ALU];
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter sharing the decode-stage register-file write port between ALU and load unit.
// Optional pending-write scoreboard with RAW/WAW stall is enabled by defining WB_SCOREBOARD_EN.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 19,
    parameter int WIDTH         = 8,
    parameter int VECTOR_SIZE   = 8,
    parameter int REGNUM        = 16,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [1:0]                      reqValid,
    output logic [1:0]                      reqReady,
    input  logic [1:0]                      reqIsVector,
    input  logic [2*ADDRESS_WIDTH-1:0]      reqAddress,
    input  logic [2*DATA_WIDTH-1:0]         reqScalarData,
    input  logic [2*VECTOR_SIZE*WIDTH-1:0]  reqVectorData,
    output logic                            writeEnableScalar,
    output logic                            writeEnableVector,
    output logic [ADDRESS_WIDTH-1:0]        writeAddress,
    output logic [DATA_WIDTH-1:0]           writeScalarData,
    output logic [VECTOR_SIZE*WIDTH-1:0]    writeVectorData,
    input  logic                            issueValid,
    input  logic                            issueIsVector,
    input  logic [ADDRESS_WIDTH-1:0]        issueDest,
    input  logic [ADDRESS_WIDTH-1:0]        issueSrc1,
    input  logic [ADDRESS_WIDTH-1:0]        issueSrc2,
    input  logic                            issueWritesDest,
    output logic                            stall,
    output logic                            issueAccept
);

    wb_req_t  reqs [2];
    wb_req_t  selReq;
    wb_port_t writePort;
    logic     transfer;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            reqs[i].isVector   = reqIsVector[i];
            reqs[i].address    = reqAddress[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            reqs[i].scalarData = reqScalarData[i*DATA_WIDTH +: DATA_WIDTH];
            reqs[i].vectorData = reqVectorData[i*VECTOR_SIZE*WIDTH +: VECTOR_SIZE*WIDTH];
        end
        selReq = reqReady[REQ_LSU] ? reqs[REQ_LSU] : reqs[REQ_ALU];
    end

    rr_arbiter2 u_arbiter (
        .clock (clock),
        .reset (reset),
        .req   (reqValid),
        .grant (reqReady)
    );

    assign transfer = |reqReady;

    // Enables pulse for one cycle per transfer; data and address hold between writes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            writePort <= '0;
        end else begin
            writePort.enScalar <= transfer & ~selReq.isVector;
            writePort.enVector <= transfer &  selReq.isVector;
            if (transfer) begin
                writePort.address    <= selReq.address;
                writePort.scalarData <= selReq.scalarData;
                writePort.vectorData <= selReq.vectorData;
            end
        end
    end

    assign writeEnableScalar = writePort.enScalar;
    assign writeEnableVector = writePort.enVector;
    assign writeAddress      = writePort.address;
    assign writeScalarData   = writePort.scalarData;
    assign writeVectorData   = writePort.vectorData;

`ifdef WB_SCOREBOARD_EN
    logic [REGNUM-1:0] pendScalar, pendVector;
    logic [REGNUM-1:0] pendScalarNext, pendVectorNext;
    logic [REGNUM-1:0] pendSel;

    always_comb begin
        pendSel = issueIsVector ? pendVector : pendScalar;
        stall   = issueValid & (pendSel[issueSrc1] | pendSel[issueSrc2] |
                                (issueWritesDest & pendSel[issueDest]));
        issueAccept = issueValid & ~stall;
    end

    // Clear on write-port load first so that a same-edge set to the same register wins.
    always_comb begin
        pendScalarNext = pendScalar;
        pendVectorNext = pendVector;
        if (transfer) begin
            if (selReq.isVector)
                pendVectorNext[selReq.address] = 1'b0;
            else
                pendScalarNext[selReq.address] = 1'b0;
        end
        if (issueAccept & issueWritesDest) begin
            if (issueIsVector)
                pendVectorNext[issueDest] = 1'b1;
            else
                pendScalarNext[issueDest] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pendScalar <= '0;
            pendVector <= '0;
        end else begin
            pendScalar <= pendScalarNext;
            pendVector <= pendVectorNext;
        end
    end
`else
    logic unusedIssue;
    assign unusedIssue = ^{issueIsVector, issueDest, issueSrc1, issueSrc2, issueWritesDest};
    assign stall       = 1'b0;
    assign issueAccept = issueValid;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed test-plan scenarios plus randomized traffic,
// checked against a queue-based reference model; write-port outputs are checked by a separate monitor.
module tb_writeback_arbiter;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   reqValid = '0;
    logic [1:0]   reqReady;
    logic [1:0]   reqIsVector = '0;
    logic [7:0]   reqAddress = '0;
    logic [37:0]  reqScalarData = '0;
    logic [127:0] reqVectorData = '0;
    logic         writeEnableScalar, writeEnableVector;
    logic [3:0]   writeAddress;
    logic [18:0]  writeScalarData;
    logic [63:0]  writeVectorData;
    logic         issueValid = 1'b0;
    logic         issueIsVector = 1'b0;
    logic [3:0]   issueDest = '0, issueSrc1 = '0, issueSrc2 = '0;
    logic         issueWritesDest = 1'b0;
    logic         stall, issueAccept;

    writeback_arbiter dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqIsVector(reqIsVector),
        .reqAddress(reqAddress), .reqScalarData(reqScalarData), .reqVectorData(reqVectorData),
        .writeEnableScalar(writeEnableScalar), .writeEnableVector(writeEnableVector),
        .writeAddress(writeAddress), .writeScalarData(writeScalarData),
        .writeVectorData(writeVectorData),
        .issueValid(issueValid), .issueIsVector(issueIsVector), .issueDest(issueDest),
        .issueSrc1(issueSrc1), .issueSrc2(issueSrc2), .issueWritesDest(issueWritesDest),
        .stall(stall), .issueAccept(issueAccept)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        bit          isVec;
        logic [3:0]  addr;
        logic [18:0] sd;
        logic [63:0] vd;
    } exp_t;

    exp_t expQ[$];
    int   cycleCount = 0;
    int   checks = 0;
    int   errors = 0;
    int   lastGrant = 1;
    bit   pendS[16];
    bit   pendV[16];

    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        lastGrant = 1;
        foreach (pendS[i]) begin
            pendS[i] = 1'b0;
            pendV[i] = 1'b0;
        end
        expQ.delete();
    endtask

    // Compares the combinational outputs with the model, then advances the model past the coming edge.
    task automatic checkOutput();
        int   g;
        bit   expStall;
        bit   hazard;
        exp_t e;
        case (reqValid)
            2'b01:   g = 0;
            2'b10:   g = 1;
            2'b11:   g = (lastGrant == 0) ? 1 : 0;
            default: g = -1;
        endcase
        check("reqReady", {62'd0, reqReady}, (g < 0) ? 64'd0 : (64'd1 << g));
        if (issueIsVector)
            hazard = pendV[issueSrc1] || pendV[issueSrc2] || (issueWritesDest && pendV[issueDest]);
        else
            hazard = pendS[issueSrc1] || pendS[issueSrc2] || (issueWritesDest && pendS[issueDest]);
        expStall = SB_EN && issueValid && hazard;
        check("stall", {63'd0, stall}, {63'd0, expStall});
        check("issueAccept", {63'd0, issueAccept}, {63'd0, issueValid && !expStall});
        if (g >= 0) begin
            e.due   = cycleCount + 1;
            e.isVec = reqIsVector[g];
            e.addr  = reqAddress[g*4 +: 4];
            e.sd    = reqScalarData[g*19 +: 19];
            e.vd    = reqVectorData[g*64 +: 64];
            expQ.push_back(e);
            lastGrant = g;
            if (e.isVec) pendV[e.addr] = 1'b0;
            else         pendS[e.addr] = 1'b0;
        end
        if (issueValid && !expStall && issueWritesDest) begin
            if (issueIsVector) pendV[issueDest] = 1'b1;
            else               pendS[issueDest] = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] isVec,
                                 input logic [3:0] a0, input logic [3:0] a1,
                                 input logic [18:0] sd0, input logic [18:0] sd1,
                                 input logic iv, input logic iIsVec, input logic [3:0] dst,
                                 input logic [3:0] s1, input logic [3:0] s2, input logic wd);
        @(posedge clock);
        #1;
        reqValid        = v;
        reqIsVector     = isVec;
        reqAddress      = {a1, a0};
        reqScalarData   = {sd1, sd0};
        reqVectorData   = {$urandom, $urandom, $urandom, $urandom};
        issueValid      = iv;
        issueIsVector   = iIsVec;
        issueDest       = dst;
        issueSrc1       = s1;
        issueSrc2       = s2;
        issueWritesDest = wd;
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 19'd0, 19'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic doReset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        check("rst_weS", {63'd0, writeEnableScalar}, 64'd0);
        check("rst_weV", {63'd0, writeEnableVector}, 64'd0);
        check("rst_addr", {60'd0, writeAddress}, 64'd0);
        check("rst_sdata", {45'd0, writeScalarData}, 64'd0);
        check("rst_vdata", writeVectorData, 64'd0);
        #10;
        reset = 1'b1;
    endtask

    // Write-port monitor: pops the expected write due this cycle, or demands idle enables.
    always @(negedge clock) begin
        if (reset) begin
            exp_t e;
            if (expQ.size() > 0 && expQ[0].due < cycleCount) begin
                e = expQ.pop_front();
                check("write_missing", 64'd0, 64'd1);
            end
            if (expQ.size() > 0 && expQ[0].due == cycleCount) begin
                e = expQ.pop_front();
                check("weScalar", {63'd0, writeEnableScalar}, {63'd0, !e.isVec});
                check("weVector", {63'd0, writeEnableVector}, {63'd0, e.isVec});
                check("writeAddress", {60'd0, writeAddress}, {60'd0, e.addr});
                if (e.isVec) check("writeVectorData", writeVectorData, e.vd);
                else         check("writeScalarData", {45'd0, writeScalarData}, {45'd0, e.sd});
            end else begin
                check("we_idle", {62'd0, writeEnableScalar, writeEnableVector}, 64'd0);
            end
        end
    end

    initial begin
        logic [1:0] grantOrder [4];
        grantOrder[0] = 2'b01; grantOrder[1] = 2'b10; grantOrder[2] = 2'b01; grantOrder[3] = 2'b10;
        modelReset();
        #3;
        check("init_weS", {63'd0, writeEnableScalar}, 64'd0);
        check("init_stall", {63'd0, stall}, 64'd0);
        #14;
        reset = 1'b1;

        // Single requester
        applyStimulus(2'b01, 2'b00, 4'd3, 4'd0, 19'h1ABCD, 19'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        check("single_ready", {62'd0, reqReady}, 64'd1);
        idle();
        check("single_weS", {63'd0, writeEnableScalar}, 64'd1);
        check("single_addr", {60'd0, writeAddress}, 64'd3);
        check("single_data", {45'd0, writeScalarData}, 64'h1ABCD);

        // Contention after reset alternates starting with requester 0
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 2'b00, 4'd1, 4'd2, $urandom, $urandom,
                          1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
            check("contend_order", {62'd0, reqReady}, {62'd0, grantOrder[i]});
        end
        idle();

        // RAW on v5
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 19'd0, 19'd0, 1'b1, 1'b1, 4'd5, 4'd0, 4'd0, 1'b1);
        check("raw_accept", {63'd0, issueAccept}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 19'd0, 19'd0, 1'b1, 1'b1, 4'd9, 4'd5, 4'd0, 1'b1);
            check("raw_stall", {63'd0, stall}, {63'd0, SB_EN});
        end
        applyStimulus(2'b10, 2'b10, 4'd0, 4'd5, 19'd0, 19'd0, 1'b1, 1'b1, 4'd9, 4'd5, 4'd0, 1'b0);
        check("raw_stall_wr", {63'd0, stall}, {63'd0, SB_EN});
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 19'd0, 19'd0, 1'b1, 1'b1, 4'd9, 4'd5, 4'd0, 1'b0);
        check("raw_release", {63'd0, stall}, 64'd0);
        check("raw_release_acc", {63'd0, issueAccept}, 64'd1);

        // WAW on s7, then a same-edge clear/set on s7 where the set wins
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 19'd0, 19'd0, 1'b1, 1'b0, 4'd7, 4'd1, 4'd1, 1'b1);
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 19'd0, 19'd0, 1'b1, 1'b0, 4'd7, 4'd1, 4'd1, 1'b1);
        check("waw_stall", {63'd0, stall}, {63'd0, SB_EN});
        applyStimulus(2'b01, 2'b00, 4'd7, 4'd0, $urandom, 19'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        applyStimulus(2'b01, 2'b00, 4'd7, 4'd0, $urandom, 19'd0, 1'b1, 1'b0, 4'd7, 4'd1, 4'd1, 1'b1);
        check("collide_accept", {63'd0, issueAccept}, 64'd1);
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 19'd0, 19'd0, 1'b1, 1'b0, 4'd2, 4'd7, 4'd1, 1'b0);
        check("collide_setwins", {63'd0, stall}, {63'd0, SB_EN});

        // Reset mid-operation with pending v4..v7 and a vector write on the port
        for (int r = 4; r < 8; r++)
            applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 19'd0, 19'd0, 1'b1, 1'b1, 4'(r), 4'd0, 4'd0, 1'b1);
        applyStimulus(2'b01, 2'b01, 4'd12, 4'd0, 19'd0, 19'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 19'd0, 19'd0, 1'b1, 1'b1, 4'd0, 4'd4, 4'd6, 1'b1);
        check("pre_reset_weV", {63'd0, writeEnableVector}, 64'd1);
        #1;
        reset = 1'b0;
        modelReset();
        #1;
        check("midrst_weV", {63'd0, writeEnableVector}, 64'd0);
        check("midrst_vdata", writeVectorData, 64'd0);
        check("midrst_stall", {63'd0, stall}, 64'd0);
        #10;
        reset = 1'b1;
        applyStimulus(2'b11, 2'b11, 4'd4, 4'd5, 19'd0, 19'd0, 1'b1, 1'b1, 4'd0, 4'd4, 4'd7, 1'b1);
        check("postrst_grant", {62'd0, reqReady}, 64'd1);
        check("postrst_stall", {63'd0, stall}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                          19'($urandom), 19'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                          4'($urandom_range(0, 7)), 1'($urandom));
        end
        idle();
        idle();
        check("queue_drained", 64'(expQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
